lane_add_node_stream: RTL and testbench



---
 rtl/neat_gene_pkg.sv | 29 ++
 rtl/lane_add_node_stream_if.sv | 22 ++
 rtl/add_node_gene_gen.sv | 29 ++
 rtl/lane_add_node_stream.sv | 140 ++++++++++++++
 tb/tb_lane_add_node_stream.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/neat_gene_pkg.sv
// Shared gene field layout, kind/mode codes and beat-sequencer state type
// for the NEAT add-node mutation stream.
package neat_gene_pkg;

  localparam int GENOME_LSB = 56;
  localparam int KIND_LSB   = 48;
  localparam int SRC_LSB    = 40;
  localparam int DST_LSB    = 32;
  localparam int WEIGHT_LSB = 16;

  localparam logic [7:0]  KIND_NODE      = 8'h01;
  localparam logic [7:0]  KIND_CONN      = 8'h02;
  localparam logic [1:0]  STATE_PASS     = 2'b00;
  localparam logic [1:0]  STATE_MUTATE   = 2'b10;
  localparam logic [15:0] WEIGHT_ONE_DEF = 16'h0100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_BEAT2,
    ST_BEAT3
  } beat_state_t;

  function automatic logic [7:0] gene_kind(input logic [63:0] gene);
    return gene[KIND_LSB +: 8];
  endfunction

endpackage

// File: rtl/lane_add_node_stream_if.sv
// Valid/ready gene stream bundle: upstream gene_in side and downstream gene_out side.
interface lane_add_node_stream_if #(
  parameter int GENE_SZ = 64
);
  logic               in_valid;
  logic               in_ready;
  logic [GENE_SZ-1:0] gene_in;
  logic               out_valid;
  logic               out_ready;
  logic [GENE_SZ-1:0] gene_out;
  logic               out_last;

  modport master (
    output in_valid, gene_in, out_ready,
    input  in_ready, out_valid, gene_out, out_last
  );

  modport slave (
    input  in_valid, gene_in, out_ready,
    output in_ready, out_valid, gene_out, out_last
  );
endinterface

// File: rtl/add_node_gene_gen.sv
// Splits one connection gene into the four genes of an add-node mutation:
// disabled original, new node, in-connection (weight 1.0), out-connection.
module add_node_gene_gen
  import neat_gene_pkg::*;
#(
  parameter logic [15:0] WEIGHT_ONE = WEIGHT_ONE_DEF
) (
  input  logic [63:0] gene,
  input  logic [7:0]  new_id,
  output logic [63:0] beat0,
  output logic [63:0] beat1,
  output logic [63:0] beat2,
  output logic [63:0] beat3
);
  logic [7:0]  genome_id;
  logic [7:0]  src;
  logic [7:0]  dst;
  logic [15:0] weight;

  assign genome_id = gene[GENOME_LSB +: 8];
  assign src       = gene[SRC_LSB +: 8];
  assign dst       = gene[DST_LSB +: 8];
  assign weight    = gene[WEIGHT_LSB +: 16];

  assign beat0 = {gene[63:1], 1'b0};
  assign beat1 = {genome_id, KIND_NODE, new_id, 8'h00, 16'h0000, 15'b0, 1'b1};
  assign beat2 = {genome_id, KIND_CONN, src, new_id, WEIGHT_ONE, 15'b0, 1'b1};
  assign beat3 = {genome_id, KIND_CONN, new_id, dst, weight, 15'b0, 1'b1};
endmodule

// File: rtl/lane_add_node_stream.sv
// Per-lane streaming add-node mutation: beat sequencer, per-genome node-ID
// allocator, and per-genome statistics (max hidden node, mutation count).
module lane_add_node_stream
  import neat_gene_pkg::*;
#(
  parameter int                   GENE_SZ    = 64,
  parameter int                   ATTR_SZ    = 8,
  parameter int                   WEIGHT_SZ  = 16,
  parameter logic [WEIGHT_SZ-1:0] WEIGHT_ONE = 16'h0100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         state,
  input  logic               genome_start,
  input  logic [ATTR_SZ-1:0] node_id_base,
  input  logic [ATTR_SZ-1:0] node_add_prob,
  input  logic [ATTR_SZ-1:0] random,
  lane_add_node_stream_if.slave strm,
  output logic [ATTR_SZ-1:0] hidden_node_max,
  output logic               id_exhausted,
  output logic [ATTR_SZ-1:0] mut_count
);
  beat_state_t        fsm_reg, fsm_next;
  logic [GENE_SZ-1:0] gene_out_reg, gene_out_next;
  logic               last_reg, last_next;
  logic [GENE_SZ-1:0] cap_gene_reg, cap_gene_next;
  logic [ATTR_SZ-1:0] cap_id_reg, cap_id_next;
  logic [ATTR_SZ-1:0] next_id_reg, next_id_next;
  logic               exh_reg, exh_next;
  logic [ATTR_SZ-1:0] mut_reg, mut_next;
  logic [ATTR_SZ-1:0] hmax_reg, hmax_next;

  logic               out_valid, in_ready, accept, fire, emit, mutate;
  logic [ATTR_SZ-1:0] alloc_id;
  logic               alloc_exh;
  logic [GENE_SZ-1:0] gen_gene;
  logic [ATTR_SZ-1:0] gen_id;
  logic [GENE_SZ-1:0] beat0, beat1, beat2, beat3;

  assign out_valid = (fsm_reg != ST_IDLE);
  assign in_ready  = !out_valid || (last_reg && strm.out_ready);
  assign accept    = strm.in_valid && in_ready;
  assign fire      = out_valid && strm.out_ready;
  assign emit      = accept && !state[0];

  // genome_start takes effect before a same-cycle accept sees the allocator
  assign alloc_id  = genome_start ? node_id_base : next_id_reg;
  assign alloc_exh = genome_start ? 1'b0 : exh_reg;

  assign mutate = accept && (state == STATE_MUTATE)
               && (gene_kind(strm.gene_in) == KIND_CONN) && strm.gene_in[0]
               && (random > node_add_prob) && !alloc_exh;

  // Generator sees the live gene on accept, the captured one while sequencing
  assign gen_gene = accept ? strm.gene_in : cap_gene_reg;
  assign gen_id   = accept ? alloc_id : cap_id_reg;

  add_node_gene_gen #(.WEIGHT_ONE(WEIGHT_ONE)) u_gen (
    .gene   (gen_gene),
    .new_id (gen_id),
    .beat0  (beat0),
    .beat1  (beat1),
    .beat2  (beat2),
    .beat3  (beat3)
  );

  always_comb begin
    fsm_next      = fsm_reg;
    gene_out_next = gene_out_reg;
    last_next     = last_reg;
    cap_gene_next = cap_gene_reg;
    cap_id_next   = cap_id_reg;
    next_id_next  = alloc_id;
    exh_next      = alloc_exh;
    mut_next      = genome_start ? '0 : mut_reg;
    hmax_next     = genome_start ? '0 : hmax_reg;

    if (mutate) begin
      cap_gene_next = strm.gene_in;
      cap_id_next   = alloc_id;
      if (alloc_id == '1) exh_next = 1'b1;
      else                next_id_next = alloc_id + ATTR_SZ'(1);
      if (mut_next != '1) mut_next = mut_next + ATTR_SZ'(1);
    end

    if (fire && (gene_kind(gene_out_reg) == KIND_NODE)
        && (gene_out_reg[SRC_LSB +: ATTR_SZ] > hmax_next))
      hmax_next = gene_out_reg[SRC_LSB +: ATTR_SZ];

    if (in_ready) begin
      if (emit) begin
        fsm_next      = ST_BEAT0;
        gene_out_next = mutate ? beat0 : strm.gene_in;
        last_next     = !mutate;
      end else begin
        fsm_next  = ST_IDLE;
        last_next = 1'b0;
      end
    end else if (fire) begin
      case (fsm_reg)
        ST_BEAT0: begin fsm_next = ST_BEAT1; gene_out_next = beat1; end
        ST_BEAT1: begin fsm_next = ST_BEAT2; gene_out_next = beat2; end
        ST_BEAT2: begin fsm_next = ST_BEAT3; gene_out_next = beat3; last_next = 1'b1; end
        default:  fsm_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg      <= ST_IDLE;
      gene_out_reg <= '0;
      last_reg     <= 1'b0;
      cap_gene_reg <= '0;
      cap_id_reg   <= '0;
      next_id_reg  <= '0;
      exh_reg      <= 1'b0;
      mut_reg      <= '0;
      hmax_reg     <= '0;
    end else begin
      fsm_reg      <= fsm_next;
      gene_out_reg <= gene_out_next;
      last_reg     <= last_next;
      cap_gene_reg <= cap_gene_next;
      cap_id_reg   <= cap_id_next;
      next_id_reg  <= next_id_next;
      exh_reg      <= exh_next;
      mut_reg      <= mut_next;
      hmax_reg     <= hmax_next;
    end
  end

  assign strm.in_ready  = in_ready;
  assign strm.out_valid = out_valid;
  assign strm.gene_out  = gene_out_reg;
  assign strm.out_last  = last_reg;
  assign hidden_node_max = hmax_reg;
  assign mut_count       = mut_reg;
  assign id_exhausted    = exh_reg;
endmodule

// File: tb/tb_lane_add_node_stream.sv
// Directed bench for lane_add_node_stream: mutation split, threshold, back-pressure,
// allocator exhaustion, drop mode and mid-group reset.
module tb_lane_add_node_stream;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;
  logic       genome_start;
  logic [7:0] node_id_base, node_add_prob, random;
  logic [7:0] hidden_node_max, mut_count;
  logic       id_exhausted;
  int         vectors = 0;
  int         miscompares = 0;

  localparam logic [63:0] G_MUT  = 64'h0502_0307_0A00_0001;
  localparam logic [63:0] G_DIS  = 64'h0502_0307_0A00_0000;
  localparam logic [63:0] G_NODE = 64'h0501_0900_0000_0001;

  lane_add_node_stream_if #(.GENE_SZ(64)) bus ();

  lane_add_node_stream dut (
    .clk             (clk),
    .rst             (rst),
    .state           (state),
    .genome_start    (genome_start),
    .node_id_base    (node_id_base),
    .node_add_prob   (node_add_prob),
    .random          (random),
    .strm            (bus),
    .hidden_node_max (hidden_node_max),
    .id_exhausted    (id_exhausted),
    .mut_count       (mut_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [63:0] exp_gene, input logic exp_last);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1'b1));
    chk({tag, "_gene"},  bus.gene_out, exp_gene);
    chk({tag, "_last"},  64'(bus.out_last), 64'(exp_last));
  endtask

  // Present one gene for exactly one accepting cycle, optionally with genome_start
  task automatic send(input logic [63:0] g, input logic gs, input logic [7:0] base);
    bus.in_valid = 1'b1;
    bus.gene_in  = g;
    genome_start = gs;
    node_id_base = base;
    tick();
    bus.in_valid = 1'b0;
    genome_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; state = 2'b10; genome_start = 1'b0;
    node_id_base = 8'h00; node_add_prob = 8'h40; random = 8'h80;
    bus.in_valid = 1'b0; bus.gene_in = '0; bus.out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
    chk("rst_in_ready",  64'(bus.in_ready), 64'(1'b1));
    chk("rst_gene_out",  bus.gene_out, 64'h0);
    chk("rst_mut",       64'(mut_count), 64'h0);
    chk("rst_hmax",      64'(hidden_node_max), 64'h0);
    chk("rst_exh",       64'(id_exhausted), 64'h0);

    // Mutation split with base 0x10 loaded on the same cycle as the accept
    send(G_MUT, 1'b1, 8'h10);
    beat("mut_b0", 64'h0502_0307_0A00_0000, 1'b0);
    chk("mut_b0_in_ready", 64'(bus.in_ready), 64'(1'b0));
    chk("mut_count1", 64'(mut_count), 64'h1);
    tick();
    beat("mut_b1", 64'h0501_1000_0000_0001, 1'b0);
    chk("mut_hmax_pre", 64'(hidden_node_max), 64'h0);
    tick();
    beat("mut_b2", 64'h0502_0310_0100_0001, 1'b0);
    chk("mut_hmax", 64'(hidden_node_max), 64'h10);
    tick();
    beat("mut_b3", 64'h0502_1007_0A00_0001, 1'b1);
    chk("mut_b3_in_ready", 64'(bus.in_ready), 64'(1'b1));
    tick();
    chk("mut_idle", 64'(bus.out_valid), 64'(1'b0));

    // Threshold (random == prob), then disabled CONN and NODE back-to-back
    random = 8'h40;
    bus.in_valid = 1'b1; bus.gene_in = G_MUT; genome_start = 1'b1; node_id_base = 8'h10;
    tick();
    genome_start = 1'b0;
    beat("thr", G_MUT, 1'b1);
    chk("thr_mut", 64'(mut_count), 64'h0);
    chk("thr_in_ready", 64'(bus.in_ready), 64'(1'b1));
    random = 8'hFF; bus.gene_in = G_DIS;
    tick();
    beat("dis", G_DIS, 1'b1);
    bus.gene_in = G_NODE;
    tick();
    beat("node", G_NODE, 1'b1);
    chk("node_mut", 64'(mut_count), 64'h0);
    bus.in_valid = 1'b0;
    tick();
    chk("node_idle", 64'(bus.out_valid), 64'(1'b0));
    chk("node_hmax", 64'(hidden_node_max), 64'h09);

    // Back-pressure held at beat1 for three cycles
    random = 8'h80;
    send(G_MUT, 1'b1, 8'h30);
    beat("bp_b0", 64'h0502_0307_0A00_0000, 1'b0);
    tick();
    bus.out_ready = 1'b0;
    beat("bp_b1", 64'h0501_3000_0000_0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      beat("bp_hold", 64'h0501_3000_0000_0001, 1'b0);
      chk("bp_in_ready", 64'(bus.in_ready), 64'(1'b0));
    end
    bus.out_ready = 1'b1;
    tick();
    beat("bp_b2", 64'h0502_0330_0100_0001, 1'b0);
    chk("bp_hmax", 64'(hidden_node_max), 64'h30);
    tick();
    beat("bp_b3", 64'h0502_3007_0A00_0001, 1'b1);
    tick();
    chk("bp_idle", 64'(bus.out_valid), 64'(1'b0));

    // Allocator exhaustion from base 0xFE
    send(G_MUT, 1'b1, 8'hFE);
    chk("ex1_exh", 64'(id_exhausted), 64'h0);
    tick();
    beat("ex1_b1", 64'h0501_FE00_0000_0001, 1'b0);
    tick(); tick(); tick();
    send(G_MUT, 1'b0, 8'h00);
    chk("ex2_exh", 64'(id_exhausted), 64'h1);
    tick();
    beat("ex2_b1", 64'h0501_FF00_0000_0001, 1'b0);
    tick(); tick(); tick();
    send(G_MUT, 1'b0, 8'h00);
    beat("ex3_pass", G_MUT, 1'b1);
    tick();
    chk("ex_mut", 64'(mut_count), 64'h2);
    chk("ex_hmax", 64'(hidden_node_max), 64'hFF);
    chk("ex_idle", 64'(bus.out_valid), 64'(1'b0));
    send(G_MUT, 1'b1, 8'h20);
    chk("ex4_exh", 64'(id_exhausted), 64'h0);
    tick();
    beat("ex4_b1", 64'h0501_2000_0000_0001, 1'b0);
    tick(); tick(); tick();

    // Drop mode: four eligible genes consumed, nothing emitted
    state = 2'b01;
    bus.in_valid = 1'b1; bus.gene_in = G_MUT; genome_start = 1'b1; node_id_base = 8'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      genome_start = 1'b0;
      chk("drop_valid", 64'(bus.out_valid), 64'(1'b0));
      chk("drop_in_ready", 64'(bus.in_ready), 64'(1'b1));
    end
    bus.in_valid = 1'b0;
    chk("drop_mut", 64'(mut_count), 64'h0);

    // Reset during beat2 discards the group
    state = 2'b10;
    send(G_MUT, 1'b1, 8'h50);
    tick();
    tick();
    beat("rg_b2", 64'h0502_0350_0100_0001, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rg_valid", 64'(bus.out_valid), 64'(1'b0));
    chk("rg_in_ready", 64'(bus.in_ready), 64'(1'b1));
    chk("rg_mut", 64'(mut_count), 64'h0);
    chk("rg_hmax", 64'(hidden_node_max), 64'h0);
    chk("rg_gene", bus.gene_out, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rg_no_residual", 64'(bus.out_valid), 64'(1'b0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
